// File: rtl/if_id_stall_ctrl.sv
// if_id_stall_ctrl: fetch PC and IF/ID register control with stall, bubble, redirect and halt.
// Optional macro IF_ID_STALL_CNT_EN adds an 8-bit saturating StallCnt output.
module if_id_stall_ctrl #(
  parameter logic [15:0] NOP_INSTR = 16'h0800,
  parameter logic [4:0]  HALT_OP   = 5'b00000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        NOP,
  input  logic        PcStall,
  input  logic        BrTaken,
  input  logic [15:0] BrTarget,
  input  logic [15:0] Instr_in,
  output logic [15:0] Pc,
  output logic [15:0] Instr_out,
  output logic [15:0] PcPlus2_out,
  output logic        valid_out,
`ifdef IF_ID_STALL_CNT_EN
  output logic [7:0]  StallCnt,
`endif
  output logic        stalled,
  output logic        halted
);
  typedef enum logic [1:0] {RUN = 2'd0, STALL = 2'd1, HALT = 2'd2} state_t;
  state_t state, next_state;
  logic [15:0] pc_plus2, pc_next;
  logic bubble, halt_entry;
  assign pc_plus2 = Pc + 16'd2;
  assign halt_entry = valid_out && (Instr_out[15:11] == HALT_OP);
  always_comb begin
    next_state = BrTaken ? RUN : (state == HALT || halt_entry) ? HALT : PcStall ? STALL : RUN;
    pc_next = BrTaken ? BrTarget : (state == HALT || PcStall) ? Pc : pc_plus2;
    bubble = BrTaken || state == HALT || PcStall || NOP;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= RUN;
    else state <= next_state;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      Pc <= 16'h0000;
      Instr_out <= NOP_INSTR;
      PcPlus2_out <= 16'h0000;
      valid_out <= 1'b0;
    end else begin
      Pc <= pc_next;
      Instr_out <= bubble ? NOP_INSTR : Instr_in;
      valid_out <= !bubble;
      if (!bubble) PcPlus2_out <= pc_plus2;
    end
`ifdef IF_ID_STALL_CNT_EN
  always_ff @(posedge clk or posedge rst)
    if (rst) StallCnt <= 8'd0;
    else StallCnt <= (next_state == STALL) ? StallCnt + {7'd0, StallCnt != 8'hFF} : 8'd0;
`endif
  assign stalled = (state == STALL);
  assign halted = (state == HALT);
endmodule
